// File: rtl/trap_pkg.sv
// Shared constants and helpers for the trap dispatcher.
package trap_pkg;

  // Privilege modes
  localparam logic [1:0] MODE_USER0 = 2'b00;
  localparam logic [1:0] MODE_USER1 = 2'b01;
  localparam logic [1:0] MODE_TRAP  = 2'b10;
  localparam logic [1:0] MODE_ADMIN = 2'b11;

  // mode_set request encodings
  localparam logic [1:0] MS_HOLD  = 2'b00;
  localparam logic [1:0] MS_USER0 = 2'b01;
  localparam logic [1:0] MS_USER1 = 2'b10;
  localparam logic [1:0] MS_RET   = 2'b11;

  // Handler entry point for source idx; caller truncates to its PC width.
  function automatic logic [31:0] vector_addr(input logic [31:0] base,
                                              input int unsigned idx,
                                              input int unsigned shift);
    return base + (idx << shift);
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index, any flag.
module trap_prio_enc #(
  parameter int unsigned N  = 8,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest set index is the last to win
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
      end
    end
    any_o = |req_i;
  end

endmodule

// File: rtl/trap_controller.sv
// Trap/interrupt dispatcher: latches pending sources, dispatches the
// highest-priority eligible one to its vector, and tracks privilege mode.
// Optional: define TRAP_CAUSE_EN to add the {valid, index} cause output.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned          NUM_SRC       = 8,
  parameter int unsigned          ADDR_W        = 16,
  parameter logic [ADDR_W-1:0]    VEC_BASE      = 16'h0100,
  parameter int unsigned          VEC_SHIFT     = 4,
  parameter logic [NUM_SRC-1:0]   SRC_SYNC      = 8'b0000_0111,
  parameter logic [NUM_SRC-1:0]   SRC_USER_ONLY = 8'b1000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss,
  input  logic [ADDR_W-1:0]   branch_pc,
  input  logic                jump,
  input  logic [ADDR_W-1:0]   new_pc,
  input  logic                stall,
  input  logic [1:0]          mode_set,
  input  logic [NUM_SRC-1:0]  src_in,
  output logic                j,
  output logic [ADDR_W-1:0]   j_r,
  output logic                store_current,
  output logic [NUM_SRC-1:0]  trap_ack,
  output logic [1:0]          mode,
  output logic                in_handler
`ifdef TRAP_CAUSE_EN
  ,
  output logic [$clog2(NUM_SRC):0] cause
`endif
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_HANDLER = 1'b1;

  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         saved_mode_q, saved_mode_d;
  logic [0:0]         state_q, state_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               dispatch;
  logic               quiet;
  logic [31:0]        vec_full;

  // User-only sources are masked while in a privileged mode
  assign eligible = pending_q & ~(SRC_USER_ONLY & {NUM_SRC{mode_q[1]}});

  trap_prio_enc #(
    .N  (NUM_SRC),
    .IW (IDX_W)
  ) u_prio_enc (
    .req_i (eligible),
    .gnt_o (grant),
    .idx_o (grant_idx),
    .any_o (grant_any)
  );

  assign quiet    = ~miss & ~stall;
  assign dispatch = quiet & (state_q == ST_IDLE) & grant_any;
  assign vec_full = vector_addr(32'(VEC_BASE), 32'(grant_idx), VEC_SHIFT);

  // Redirect arbitration: miss, stall, trap, jump
  always_comb begin
    j             = 1'b0;
    j_r           = '0;
    store_current = 1'b0;
    trap_ack      = '0;
    if (miss) begin
      j   = 1'b1;
      j_r = branch_pc;
    end else if (stall) begin
      j   = 1'b0;
    end else if (dispatch) begin
      j             = 1'b1;
      j_r           = vec_full[ADDR_W-1:0];
      store_current = 1'b1;
      trap_ack      = grant;
    end else if (jump) begin
      j   = 1'b1;
      j_r = new_pc;
    end
  end

  // Next-state: pending capture (set wins), dispatch and mode changes
  always_comb begin
    pending_d    = (pending_q & ~(dispatch ? grant : '0))
                 | (src_in & ~(SRC_SYNC & {NUM_SRC{miss}}));
    mode_d       = mode_q;
    saved_mode_d = saved_mode_q;
    state_d      = state_q;
    if (dispatch) begin
      saved_mode_d = mode_q;
      mode_d       = MODE_TRAP;
      state_d      = ST_HANDLER;
    end else if (quiet) begin
      unique case (mode_set)
        MS_USER0: mode_d = MODE_USER0;
        MS_USER1: mode_d = MODE_USER1;
        MS_RET: begin
          if (state_q == ST_HANDLER) begin
            mode_d  = saved_mode_q;
            state_d = ST_IDLE;
          end else begin
            mode_d = {1'b0, mode_q[0]};
          end
        end
        default: mode_d = mode_q;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      mode_q       <= MODE_ADMIN;
      saved_mode_q <= MODE_ADMIN;
      state_q      <= ST_IDLE;
    end else begin
      pending_q    <= pending_d;
      mode_q       <= mode_d;
      saved_mode_q <= saved_mode_d;
      state_q      <= state_d;
    end
  end

  assign mode       = mode_q;
  assign in_handler = (state_q == ST_HANDLER);

`ifdef TRAP_CAUSE_EN
  logic [IDX_W:0] cause_q;

  // Cause held for the whole handler, cleared on return
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else if (dispatch) begin
      cause_q <= {1'b1, grant_idx};
    end else if (quiet && state_q == ST_HANDLER && mode_set == MS_RET) begin
      cause_q <= '0;
    end
  end

  assign cause = cause_q;
`endif

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: inputs change 1 time unit after the
// rising edge, outputs are checked 2 units later, mid-cycle.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss;
  logic [15:0] branch_pc;
  logic        jump;
  logic [15:0] new_pc;
  logic        stall;
  logic [1:0]  mode_set;
  logic [7:0]  src_in;
  logic        j;
  logic [15:0] j_r;
  logic        store_current;
  logic [7:0]  trap_ack;
  logic [1:0]  mode;
  logic        in_handler;
`ifdef TRAP_CAUSE_EN
  logic [3:0]  cause;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk           (clk),
    .rst           (rst),
    .miss          (miss),
    .branch_pc     (branch_pc),
    .jump          (jump),
    .new_pc        (new_pc),
    .stall         (stall),
    .mode_set      (mode_set),
    .src_in        (src_in),
    .j             (j),
    .j_r           (j_r),
    .store_current (store_current),
    .trap_ack      (trap_ack),
    .mode          (mode),
    .in_handler    (in_handler)
`ifdef TRAP_CAUSE_EN
    ,
    .cause         (cause)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Check all redirect outputs at once
  task automatic chk_out(input string tag, input logic ej, input logic [15:0] ejr,
                         input logic es, input logic [7:0] eack);
    chk({tag, ".j"}, 32'(j), 32'(ej));
    chk({tag, ".j_r"}, 32'(j_r), 32'(ejr));
    chk({tag, ".store"}, 32'(store_current), 32'(es));
    chk({tag, ".ack"}, 32'(trap_ack), 32'(eack));
  endtask

  task automatic chk_st(input string tag, input logic [1:0] em, input logic eh);
    chk({tag, ".mode"}, 32'(mode), 32'(em));
    chk({tag, ".in_handler"}, 32'(in_handler), 32'(eh));
  endtask

  // Advance to just after the next rising edge, clear stimulus
  task automatic next_cycle();
    @(posedge clk);
    #1;
    miss = 0; jump = 0; stall = 0; mode_set = 2'b00; src_in = '0; rst = 0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    rst = 1; miss = 0; branch_pc = '0; jump = 0; new_pc = '0;
    stall = 0; mode_set = 2'b00; src_in = '0;
    @(posedge clk);
    @(posedge clk);
    #1; rst = 0;

    // Reset state
    settle();
    chk_st("reset", 2'b11, 1'b0);
    chk_out("reset", 1'b0, 16'h0000, 1'b0, 8'h00);

    // Single source 2: not dispatched in the cycle it is raised
    src_in = 8'h04; settle();
    chk_out("t1_raise", 1'b0, 16'h0000, 1'b0, 8'h00);
    next_cycle(); settle();
    chk_out("t1_disp", 1'b1, 16'h0120, 1'b1, 8'h04);
    next_cycle(); settle();
    chk_st("t1_hdl", 2'b10, 1'b1);
    chk_out("t1_hdl", 1'b0, 16'h0000, 1'b0, 8'h00);
    mode_set = 2'b11;
    next_cycle(); settle();
    chk_st("t1_ret", 2'b11, 1'b0);

    // Sources 1 and 3 together: 1 first, 3 after return
    src_in = 8'h0A;
    next_cycle(); settle();
    chk_out("t2_s1", 1'b1, 16'h0110, 1'b1, 8'h02);
    next_cycle(); settle();
    chk_out("t2_nonest", 1'b0, 16'h0000, 1'b0, 8'h00);
    mode_set = 2'b11;
    next_cycle(); settle();
    chk_st("t2_ret", 2'b11, 1'b0);
    chk_out("t2_s3", 1'b1, 16'h0130, 1'b1, 8'h08);
    next_cycle(); mode_set = 2'b11;
    next_cycle(); settle();
    chk_st("t2_ret2", 2'b11, 1'b0);
    chk_out("t2_idle", 1'b0, 16'h0000, 1'b0, 8'h00);

    // Miss drops sync source 0 but keeps async source 5
    src_in = 8'h21; miss = 1; branch_pc = 16'h2222; settle();
    chk_out("t3_miss", 1'b1, 16'h2222, 1'b0, 8'h00);
    next_cycle(); settle();
    chk_out("t3_s5", 1'b1, 16'h0150, 1'b1, 8'h20);
    next_cycle(); mode_set = 2'b11;
    next_cycle(); settle();
    chk_out("t3_no_s0", 1'b0, 16'h0000, 1'b0, 8'h00);

    // User-only source 7 masked in admin mode
    src_in = 8'h80;
    next_cycle(); settle();
    chk_out("t4_masked", 1'b0, 16'h0000, 1'b0, 8'h00);
    mode_set = 2'b01;
    next_cycle(); settle();
    chk_st("t4_user0", 2'b00, 1'b0);
    chk_out("t4_s7", 1'b1, 16'h0170, 1'b1, 8'h80);
    next_cycle(); settle();
    chk_st("t4_hdl", 2'b10, 1'b1);
    mode_set = 2'b11;
    next_cycle(); settle();
    chk_st("t4_ret", 2'b00, 1'b0);

    // Stall holds dispatch and mode for 3 cycles
    src_in = 8'h02; stall = 1; mode_set = 2'b10; settle();
    chk_out("t5_st0", 1'b0, 16'h0000, 1'b0, 8'h00);
    for (int c = 1; c < 3; c++) begin
      next_cycle(); stall = 1; mode_set = 2'b10; settle();
      chk_out("t5_st", 1'b0, 16'h0000, 1'b0, 8'h00);
      chk_st("t5_st", 2'b00, 1'b0);
    end
    next_cycle(); settle();
    chk_out("t5_go", 1'b1, 16'h0110, 1'b1, 8'h02);
    next_cycle(); settle();
    chk_st("t5_hdl", 2'b10, 1'b1);

    // Jump passes through while in handler; source 4 stays pending
    jump = 1; new_pc = 16'h3456; src_in = 8'h10; settle();
    chk_out("t6_jump", 1'b1, 16'h3456, 1'b0, 8'h00);
    next_cycle(); settle();
    chk_out("t6_pend", 1'b0, 16'h0000, 1'b0, 8'h00);

    // Reset mid-handler discards pending
    rst = 1;
    next_cycle(); settle();
    chk_st("t6_rst", 2'b11, 1'b0);
    chk_out("t6_rst", 1'b0, 16'h0000, 1'b0, 8'h00);
    next_cycle(); settle();
    chk_out("t6_after", 1'b0, 16'h0000, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_controller.md
Name: trap_controller

Overview:
- Parametrised trap/interrupt dispatcher for the 16-bit pipeline front end. Generalises the fixed five-source monitor.
- Accepts NUM_SRC trap sources and latches them as pending. Selects the highest-priority eligible source and redirects fetch to a computed vector.
- Tracks the privilege mode and saves/restores it across a handler. Arbitrates redirects in this order: branch mispredict, stall, trap, jump.

Parameters:
NUM_SRC, 8, number of trap sources; index 0 is highest priority
ADDR_W, 16, PC width
VEC_BASE, 16'h0100, vector of source 0
VEC_SHIFT, 4, vector spacing; vector(i) = VEC_BASE + (i << VEC_SHIFT)
SRC_SYNC, 8'b0000_0111, bitmap of synchronous (instruction-caused) sources; these are dropped when miss=1
SRC_USER_ONLY, 8'b1000_0000, bitmap of sources eligible only when mode[1]=0

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
miss  in  1  branch mispredict; redirect to branch_pc
branch_pc  in  ADDR_W  corrected PC on miss
jump  in  1  decoded jump
new_pc  in  ADDR_W  jump target
stall  in  1  IF/ID stall
mode_set  in  2  01: go to mode 00; 10: go to mode 01; 11: return from trap
src_in  in  NUM_SRC  trap requests, level
j  out  1  redirect fetch
j_r  out  ADDR_W  redirect target
store_current  out  1  save current PC as return address
trap_ack  out  NUM_SRC  one-hot; high in the dispatch cycle
mode  out  2  privilege mode; 11 = admin/boot
in_handler  out  1  a trap is being serviced

Behaviour:
- Reset values:
  - mode=2'b11, saved_mode=2'b11.
  - pending=0, in_handler=0.
  - j=0, j_r=0, store_current=0, trap_ack=0.
- Pending capture, every posedge:
  - pending[i] <= pending[i] | (src_in[i] & ~(SRC_SYNC[i] & miss)).
  - A source raised in cycle N can dispatch no earlier than cycle N+1.
  - Set wins over clear when src_in[i] is high in the cycle pending[i] is acked.
- Eligibility: eligible = pending & ~(SRC_USER_ONLY & {NUM_SRC{mode[1]}}). Priority is fixed; the lowest set index wins.
- Dispatch condition: ~miss & ~stall & ~in_handler & |eligible.
- Combinational output, priority order:
  1. miss: j=1, j_r=branch_pc, store_current=0.
  2. stall: j=0, j_r=0.
  3. dispatch of index k: j=1, j_r=VEC_BASE+(k<<VEC_SHIFT) truncated to ADDR_W, store_current=1, trap_ack[k]=1.
  4. jump: j=1, j_r=new_pc.
  5. Otherwise: j=0, j_r=0.
- On dispatch, next edge: pending[k] cleared (subject to set-wins), saved_mode<=mode, mode<=2'b10, in_handler<=1.
- States: IDLE (in_handler=0) and HANDLER (in_handler=1).
  - IDLE->HANDLER on dispatch.
  - HANDLER->IDLE when mode_set=11 and ~stall and ~miss; mode<=saved_mode.
  - In HANDLER, new requests stay pending; there is no nesting.
- mode_set handling when no dispatch, ~stall and ~miss:
  - 01 -> mode 00.
  - 10 -> mode 01.
  - 11 in IDLE -> mode<={1'b0,mode[0]}.
  - 00 -> hold.
- A dispatch mode update overrides a same-cycle mode_set.
- stall or miss: mode and the state machine hold; pending capture continues.
- rst mid-handler: all state returns to reset values and pending is lost.

Optional Feature:
- Macro TRAP_CAUSE_EN.
- Defined: adds output cause, width $clog2(NUM_SRC)+1, as {valid, index}. Loaded at dispatch with {1,k}, held through HANDLER, cleared to 0 on return and on reset.
- Undefined: the port is absent and no cause register exists.

Decomposition:
- Package trap_pkg holds:
  - MODE_ADMIN=2'b11, MODE_TRAP=2'b10, MODE_USER0=2'b00, MODE_USER1=2'b01;
  - mode_set encodings as constants;
  - a vector_addr function.
- Sub-module trap_prio_enc: a parametrised lowest-index priority encoder producing a one-hot grant, the index and an any flag.

Test Plan:
- Reset, then src_in=8'h04 for one cycle -> next cycle j=1, j_r=16'h0120, store_current=1, trap_ack=8'h04; then mode=10, in_handler=1.
- src_in=8'h0A together -> source 1 dispatches (j_r=16'h0110); pending[3] held; mode_set=11 -> mode restored, then source 3 dispatches (j_r=16'h0130).
- src_in[0]=1 with miss=1 (synchronous) -> never dispatched; src_in[5]=1 with miss=1 (asynchronous) -> dispatched once miss=0.
- src_in[7] while mode=11 -> no dispatch; after mode_set=01 (mode 00) -> j_r=16'h0170.
- Pending source with stall=1 for 3 cycles -> j=0 throughout, mode unchanged; dispatch in the first cycle with stall=0.
- rst asserted during HANDLER with pending=8'h10 -> mode=11, in_handler=0, pending=0, no redirect afterwards.
